// File: rtl/mc_control_unit.sv
// mc_control_unit
//   Multi-cycle instruction control unit. Accepts one instruction per
//   INSTR_VALID/INSTR_READY handshake, latches its decode, and drives
//   datapath controls from the registered state: one EXEC cycle for ALU and
//   branch ops, or a MEM phase (held against BUSYWAIT, watched by a stall
//   timer) followed by a WB cycle for loads and stores.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   INSTRUCTION           instruction word, opcode in the top 8 bits
//   INSTR_VALID/READY     fetch handshake; READY doubles as the PC stall
//   BUSYWAIT              data memory busy
//   WRITEENABLE .. LOAD_WORD_FLAG, ALUOP   datapath controls
//   ILLEGAL_OP            one-cycle pulse for an undefined opcode
//   MEM_TIMEOUT_ERR       sticky memory watchdog error
//   RETIRED_COUNT         retired-instruction counter (wraps)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new instruction, all controls low
// EXEC  | single-cycle ALU / branch / jump controls
// MEM   | READ or WRITE held until memory answers or the timer expires
// WB    | load write-back (stores retire with all controls low)
// ILL   | undefined opcode, ILLEGAL_OP pulse
// ERR   | memory watchdog tripped, parked until RESET
module mc_control_unit #(
  parameter int INSTR_W     = 32,
  parameter int ALUOP_W     = 3,
  parameter int EXT_OPS     = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTRUCTION,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic               BUSYWAIT,
  output logic               WRITEENABLE,
  output logic               COMPLEMENT_FLAG,
  output logic               IMMEDIATE_FLAG,
  output logic               BRANCH_FLAG,
  output logic               BRANCH_NE_FLAG,
  output logic               JUMP_FLAG,
  output logic               READ,
  output logic               WRITE,
  output logic               LOAD_WORD_FLAG,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               ILLEGAL_OP,
  output logic               MEM_TIMEOUT_ERR,
  output logic [CNT_W-1:0]   RETIRED_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_ILL  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  typedef struct packed {
    logic               we;
    logic               cmp;
    logic               imm;
    logic               br;
    logic               bne;
    logic               jmp;
    logic               rd;
    logic               wr;
    logic               lw;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam logic [ALUOP_W-1:0] ALU_FWD  = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_MULT = ALUOP_W'(3'b110);

  // Stall timer counts down from MEM_TIMEOUT; terminal count is 1.
  localparam int TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             first_q, first_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t      dec;
  logic       dec_legal;
  logic       dec_mem;
  logic [7:0] opcode;
  logic       unused_instr_bits;

  assign opcode            = INSTRUCTION[INSTR_W-1 -: 8];
  assign unused_instr_bits = ^INSTRUCTION[INSTR_W-9:0];

  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    case (opcode)
      8'h00: begin dec.we = 1'b1; dec.imm = 1'b1; dec.aluop = ALU_FWD; end
      8'h01: begin dec.we = 1'b1; dec.aluop = ALU_FWD; end
      8'h02: begin dec.we = 1'b1; dec.aluop = ALU_ADD; end
      8'h03: begin dec.we = 1'b1; dec.cmp = 1'b1; dec.aluop = ALU_ADD; end
      8'h04: begin dec.we = 1'b1; dec.aluop = ALU_AND; end
      8'h05: begin dec.we = 1'b1; dec.aluop = ALU_OR; end
      8'h06: dec.jmp = 1'b1;
      8'h07: begin dec.br = 1'b1; dec.cmp = 1'b1; dec.aluop = ALU_ADD; end
      8'h08: begin dec.rd = 1'b1; dec.lw = 1'b1; dec.we = 1'b1; end
      8'h09: begin dec.rd = 1'b1; dec.lw = 1'b1; dec.we = 1'b1; dec.imm = 1'b1; end
      8'h0A: dec.wr = 1'b1;
      8'h0B: begin dec.wr = 1'b1; dec.imm = 1'b1; end
      8'h0C: begin
        if (EXT_OPS != 0) begin
          dec.br = 1'b1; dec.bne = 1'b1; dec.cmp = 1'b1; dec.aluop = ALU_ADD;
        end else begin
          dec_legal = 1'b0;
        end
      end
      8'h0D: begin
        if (EXT_OPS != 0) begin dec.we = 1'b1; dec.aluop = ALU_SLL; end
        else dec_legal = 1'b0;
      end
      8'h0E: begin
        if (EXT_OPS != 0) begin dec.we = 1'b1; dec.aluop = ALU_SRL; end
        else dec_legal = 1'b0;
      end
      8'h0F: begin
        if (EXT_OPS != 0) begin dec.we = 1'b1; dec.aluop = ALU_MULT; end
        else dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_mem = dec.rd | dec.wr;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      first_q <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      first_q <= first_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    first_d = first_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (INSTR_VALID) begin
          ctrl_d  = dec_legal ? dec : '0;
          first_d = 1'b1;
          tmo_d   = TMO_LOAD;
          if (!dec_legal)   state_d = S_ILL;
          else if (dec_mem) state_d = S_MEM;
          else              state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_MEM: begin
        first_d = 1'b0;
        // The first MEM cycle gives the memory a chance to raise BUSYWAIT.
        if (!first_q) begin
          if (!BUSYWAIT) begin
            state_d = S_WB;
          end else if (MEM_TIMEOUT != 0) begin
            if (tmo_q == TMO_W'(1)) state_d = S_ERR;
            else                    tmo_d   = tmo_q - TMO_W'(1);
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ILL:   state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    WRITEENABLE     = 1'b0;
    COMPLEMENT_FLAG = 1'b0;
    IMMEDIATE_FLAG  = 1'b0;
    BRANCH_FLAG     = 1'b0;
    BRANCH_NE_FLAG  = 1'b0;
    JUMP_FLAG       = 1'b0;
    READ            = 1'b0;
    WRITE           = 1'b0;
    LOAD_WORD_FLAG  = 1'b0;
    ALUOP           = '0;
    ILLEGAL_OP      = 1'b0;
    MEM_TIMEOUT_ERR = 1'b0;
    case (state_q)
      S_EXEC: begin
        WRITEENABLE     = ctrl_q.we;
        COMPLEMENT_FLAG = ctrl_q.cmp;
        IMMEDIATE_FLAG  = ctrl_q.imm;
        BRANCH_FLAG     = ctrl_q.br;
        BRANCH_NE_FLAG  = ctrl_q.bne;
        JUMP_FLAG       = ctrl_q.jmp;
        LOAD_WORD_FLAG  = ctrl_q.lw;
        ALUOP           = ctrl_q.aluop;
      end
      S_MEM: begin
        // Register file write is deferred to WB so a stalled load never
        // writes stale data.
        READ           = ctrl_q.rd;
        WRITE          = ctrl_q.wr;
        IMMEDIATE_FLAG = ctrl_q.imm;
        LOAD_WORD_FLAG = ctrl_q.lw;
        ALUOP          = ctrl_q.aluop;
      end
      S_WB: begin
        if (ctrl_q.rd) begin
          WRITEENABLE    = 1'b1;
          LOAD_WORD_FLAG = 1'b1;
          IMMEDIATE_FLAG = ctrl_q.imm;
          ALUOP          = ctrl_q.aluop;
        end
      end
      S_ILL:   ILLEGAL_OP      = 1'b1;
      S_ERR:   MEM_TIMEOUT_ERR = 1'b1;
      default: ;
    endcase
  end

  assign INSTR_READY   = (state_q == S_IDLE) && !RESET;
  assign RETIRED_COUNT = cnt_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit. Two instances share stimulus:
//   dut_a: EXT_OPS=1, MEM_TIMEOUT=4, CNT_W=16
//   dut_b: EXT_OPS=0, MEM_TIMEOUT=0 (watchdog off), CNT_W=4
// Expected outputs come from a per-instruction timeline model: for an
// accepted opcode and a chosen BUSYWAIT stall length, the expected
// output vector at cycle c after acceptance is computed directly.
module tb_mc_control_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        VALID;
  logic        BUSY;

  logic rdy_a, we_a, cmp_a, imm_a, br_a, bne_a, jmp_a, rd_a, wr_a, lw_a, ill_a, err_a;
  logic [2:0]  alu_a;
  logic [15:0] rc_a;
  logic rdy_b, we_b, cmp_b, imm_b, br_b, bne_b, jmp_b, rd_b, wr_b, lw_b, ill_b, err_b;
  logic [2:0]  alu_b;
  logic [3:0]  rc_b;

  int checks = 0;
  int errors = 0;
  int cnt_a  = 0;
  int cnt_b  = 0;

  localparam int TMO_A = 4;
  localparam int TMO_B = 0;
  localparam int NCAP  = 12;

  // vector: {ready, we, cmp, imm, br, bne, jmp, rd, wr, lw, aluop[2:0], ill, err}
  localparam logic [14:0] V_IDLE = 15'h4000;
  localparam logic [14:0] V_ILL  = 15'h0002;
  localparam logic [14:0] V_ERR  = 15'h0001;
  localparam logic [14:0] B_WE   = 15'h2000;
  localparam logic [14:0] B_RD   = 15'h0080;

  logic [14:0] obs_a, obs_b;
  assign obs_a = {rdy_a, we_a, cmp_a, imm_a, br_a, bne_a, jmp_a, rd_a, wr_a, lw_a, alu_a, ill_a, err_a};
  assign obs_b = {rdy_b, we_b, cmp_b, imm_b, br_b, bne_b, jmp_b, rd_b, wr_b, lw_b, alu_b, ill_b, err_b};

  mc_control_unit #(.INSTR_W(32), .ALUOP_W(3), .EXT_OPS(1), .MEM_TIMEOUT(TMO_A), .CNT_W(16)) dut_a (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTR), .INSTR_VALID(VALID), .INSTR_READY(rdy_a),
    .BUSYWAIT(BUSY), .WRITEENABLE(we_a), .COMPLEMENT_FLAG(cmp_a), .IMMEDIATE_FLAG(imm_a),
    .BRANCH_FLAG(br_a), .BRANCH_NE_FLAG(bne_a), .JUMP_FLAG(jmp_a), .READ(rd_a), .WRITE(wr_a),
    .LOAD_WORD_FLAG(lw_a), .ALUOP(alu_a), .ILLEGAL_OP(ill_a), .MEM_TIMEOUT_ERR(err_a),
    .RETIRED_COUNT(rc_a)
  );

  mc_control_unit #(.INSTR_W(32), .ALUOP_W(3), .EXT_OPS(0), .MEM_TIMEOUT(TMO_B), .CNT_W(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTR), .INSTR_VALID(VALID), .INSTR_READY(rdy_b),
    .BUSYWAIT(BUSY), .WRITEENABLE(we_b), .COMPLEMENT_FLAG(cmp_b), .IMMEDIATE_FLAG(imm_b),
    .BRANCH_FLAG(br_b), .BRANCH_NE_FLAG(bne_b), .JUMP_FLAG(jmp_b), .READ(rd_b), .WRITE(wr_b),
    .LOAD_WORD_FLAG(lw_b), .ALUOP(alu_b), .ILLEGAL_OP(ill_b), .MEM_TIMEOUT_ERR(err_b),
    .RETIRED_COUNT(rc_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] mk(input bit we, input bit cmp, input bit imm, input bit br,
                                     input bit bne, input bit jmp, input bit rd, input bit wr,
                                     input bit lw, input logic [2:0] alu);
    return {1'b0, we, cmp, imm, br, bne, jmp, rd, wr, lw, alu, 2'b00};
  endfunction

  // Decode table for legal opcodes.
  function automatic logic [14:0] dec_vec(input logic [7:0] op);
    case (op)
      8'h00: return mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0);
      8'h01: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
      8'h02: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1);
      8'h03: return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd1);
      8'h04: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2);
      8'h05: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3);
      8'h06: return mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0);
      8'h07: return mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 3'd1);
      8'h08: return mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 3'd0);
      8'h09: return mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 3'd0);
      8'h0A: return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0);
      8'h0B: return mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 3'd0);
      8'h0C: return mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 3'd1);
      8'h0D: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd4);
      8'h0E: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd5);
      8'h0F: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd6);
      default: return 15'h0000;
    endcase
  endfunction

  function automatic bit is_legal(input bit ext, input logic [7:0] op);
    return (op <= 8'h0B) || (ext && (op <= 8'h0F));
  endfunction

  function automatic bit is_mem(input bit ext, input logic [7:0] op);
    return is_legal(ext, op) && (op >= 8'h08) && (op <= 8'h0B);
  endfunction

  // Memory op with k stalled cycles trips the watchdog when k >= timeout.
  function automatic bit trips(input bit ext, input int tmo, input logic [7:0] op, input int k);
    return is_mem(ext, op) && (tmo != 0) && (k >= tmo);
  endfunction

  // Number of cycles after acceptance until the unit is back in IDLE
  // (for a tripped op: MEM cycles plus two ERR cycles worth checking).
  function automatic int trace_len(input bit ext, input int tmo, input logic [7:0] op, input int k);
    if (!is_mem(ext, op))      return 1;
    if (trips(ext, tmo, op, k)) return tmo + 3;
    return k + 3;
  endfunction

  function automatic logic [14:0] expect_at(input bit ext, input int tmo, input logic [7:0] op,
                                            input int k, input int c);
    logic [14:0] d;
    int mc;
    if (!is_legal(ext, op)) return (c == 1) ? V_ILL : V_IDLE;
    d = dec_vec(op);
    if (!is_mem(ext, op)) return (c == 1) ? d : V_IDLE;
    mc = trips(ext, tmo, op, k) ? tmo + 1 : k + 2;
    if (c <= mc) return d & ~B_WE;
    if (trips(ext, tmo, op, k)) return V_ERR;
    if (c == mc + 1) return d[7] ? (d & ~B_RD) : 15'h0000;
    return V_IDLE;
  endfunction

  task automatic reset_dut();
    RESET = 1'b1;
    VALID = 1'($urandom_range(0, 1));
    INSTR = $urandom;
    #1;
    chk("rst_ready_a", 32'(rdy_a), 32'd0);
    chk("rst_ready_b", 32'(rdy_b), 32'd0);
    @(negedge CLK);
    chk("rst_vec_a", 32'(obs_a), 32'd0);
    chk("rst_vec_b", 32'(obs_b), 32'd0);
    chk("rst_cnt_a", 32'(rc_a), 32'd0);
    chk("rst_cnt_b", 32'(rc_b), 32'd0);
    RESET = 1'b0;
    VALID = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    @(negedge CLK);
    chk("post_rst_a", 32'(obs_a), 32'(V_IDLE));
    chk("post_rst_b", 32'(obs_b), 32'(V_IDLE));
  endtask

  // Issue one instruction. k = stalled MEM cycles after the first one,
  // abort_c = cycle after acceptance at which RESET is raised (0 = none),
  // gap = idle cycles before acceptance (-1 = random).
  task automatic run_op(input logic [31:0] iw, input int k, input int abort_c, input int gap);
    logic [7:0] op;
    int ng, la, lb, n, lmin;
    bit ta, tb, do_rst;
    op = iw[31:24];
    ng = (gap < 0) ? $urandom_range(0, 2) : gap;
    for (int g = 0; g < ng; g++) begin
      chk("idle_a", 32'(obs_a), 32'(V_IDLE));
      chk("idle_b", 32'(obs_b), 32'(V_IDLE));
      VALID = 1'b0;
      INSTR = $urandom;
      BUSY  = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    chk("accept_a", 32'(obs_a), 32'(V_IDLE));
    chk("accept_b", 32'(obs_b), 32'(V_IDLE));
    chk("cnt_a", 32'(rc_a), 32'(cnt_a) & 32'hFFFF);
    chk("cnt_b", 32'(rc_b), 32'(cnt_b) & 32'hF);
    INSTR = iw;
    VALID = 1'b1;
    BUSY  = 1'($urandom_range(0, 1));
    @(negedge CLK);

    la = trace_len(1'b1, TMO_A, op, k);
    lb = trace_len(1'b0, TMO_B, op, k);
    ta = !trips(1'b1, TMO_A, op, k);
    tb = !trips(1'b0, TMO_B, op, k);
    n  = (la > lb) ? la : lb;
    do_rst = !ta || !tb || (n > NCAP);
    if (n > NCAP) n = NCAP;
    lmin = n;
    if (ta && la < lmin) lmin = la;
    if (tb && lb < lmin) lmin = lb;

    for (int c = 1; c <= n; c++) begin
      chk($sformatf("vec_a op=%02h k=%0d c=%0d", op, k, c), 32'(obs_a),
          32'(expect_at(1'b1, TMO_A, op, k, c)));
      chk($sformatf("vec_b op=%02h k=%0d c=%0d", op, k, c), 32'(obs_b),
          32'(expect_at(1'b0, TMO_B, op, k, c)));
      if (c == abort_c) begin
        reset_dut();
        return;
      end
      if (c == 1 || c > k + 2) BUSY = 1'($urandom_range(0, 1));
      else                     BUSY = (c - 1 <= k);
      VALID = (c <= lmin) ? 1'($urandom_range(0, 1)) : 1'b0;
      INSTR = $urandom;
      @(negedge CLK);
    end

    if (do_rst) begin
      reset_dut();
    end else begin
      if (is_legal(1'b1, op)) cnt_a++;
      if (is_legal(1'b0, op)) cnt_b++;
    end
  endtask

  function automatic logic [7:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(16, 255));
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    RESET = 1'b1;
    VALID = 1'b0;
    BUSY  = 1'b0;
    INSTR = '0;
    @(negedge CLK);
    reset_dut();

    // add, then back-to-back sub / beq
    run_op(32'h02050302, 0, 0, 0);
    run_op({8'h03, 24'($urandom)}, 0, 0, 0);
    run_op({8'h07, 24'($urandom)}, 0, 0, 0);
    // lwd with 5 stalls: dut_a trips its 4-cycle watchdog, dut_b completes
    run_op({8'h08, 24'($urandom)}, 5, 0, -1);
    // swi with BUSYWAIT stuck high
    run_op({8'h0B, 24'($urandom)}, 1000, 0, -1);
    // extension opcode: executes on dut_a, illegal on dut_b
    run_op({8'h0D, 24'($urandom)}, 0, 0, -1);
    // lwi aborted by RESET on its 2nd MEM cycle
    run_op({8'h09, 24'($urandom)}, 2, 2, -1);
    // loads and stores completing just under the watchdog limit
    run_op({8'h09, 24'($urandom)}, 3, 0, -1);
    run_op({8'h0A, 24'($urandom)}, 0, 0, -1);

    // enough non-memory retires to wrap dut_b's 4-bit counter
    for (int i = 0; i < 18; i++)
      run_op({8'($urandom_range(0, 7)), 24'($urandom)}, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int k, ab;
      k  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      ab = ($urandom_range(0, 11) == 0) ? $urandom_range(1, 3) : 0;
      run_op({rand_op(), 24'($urandom)}, k, ab, -1);
    end

    chk("final_cnt_a", 32'(rc_a), 32'(cnt_a) & 32'hFFFF);
    chk("final_cnt_b", 32'(rc_b), 32'(cnt_b) & 32'hF);
    chk("final_idle_a", 32'(obs_a), 32'(V_IDLE));
    chk("final_idle_b", 32'(obs_b), 32'(V_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
